mpc_qp_admm_vec_port_ctrl: RTL and testbench

//  Initiator side of the ADMM single-port vector RAM interface (address0/ce0/we0/d0/q0, 1-cycle read-first).

---
 rtl/mpc_qp_admm_vec_port_ctrl_if.sv | 38 +++
 rtl/mpc_qp_admm_vec_port_ctrl.sv | 110 +++++++++++
 tb/tb_mpc_qp_admm_vec_port_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mpc_qp_admm_vec_port_ctrl_if.sv
// mpc_qp_admm_vec_port_ctrl_if: command, stream, status and RAM-port bundle for the vector port controller.
// slave is the controller's view; master is the solver/RAM side.
interface mpc_qp_admm_vec_port_ctrl_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [AddressWidth-1:0] cmd_base;
    logic [AddressWidth:0]   cmd_len;
    logic                    in_valid;
    logic                    in_ready;
    logic [DataWidth-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DataWidth-1:0]    out_data;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [AddressWidth-1:0] ram_address0;
    logic                    ram_ce0;
    logic                    ram_we0;
    logic [DataWidth-1:0]    ram_d0;
    logic [DataWidth-1:0]    ram_q0;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len, in_valid, in_data, out_ready, ram_q0,
        input  cmd_ready, in_ready, out_valid, out_data, busy, done, err,
               ram_address0, ram_ce0, ram_we0, ram_d0
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, in_valid, in_data, out_ready, ram_q0,
        output cmd_ready, in_ready, out_valid, out_data, busy, done, err,
               ram_address0, ram_ce0, ram_we0, ram_d0
    );
endinterface

// File: rtl/mpc_qp_admm_vec_port_ctrl.sv
// mpc_qp_admm_vec_port_ctrl: load/dump spans between valid/ready streams and a 1-cycle read-first RAM.
// Define MPC_VEC_CLEAR_EN to enable op=2 CLEAR (zero-fill); otherwise op=2 is reserved.
module mpc_qp_admm_vec_port_ctrl #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 5,
    parameter int AddressRange = 24
) (
    input logic clk,
    input logic reset,
    mpc_qp_admm_vec_port_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP,
`ifdef MPC_VEC_CLEAR_EN
        CLEAR,
`endif
        DONE
    } state_t;

    localparam logic [AddressWidth:0] range_w = (AddressWidth + 1)'(AddressRange);
    localparam logic [AddressWidth:0] one_w   = (AddressWidth + 1)'(1);

    state_t                  state, nstate;
    logic [AddressWidth-1:0] base;
    logic [AddressWidth:0]   len, idx, avail, eff, addr_sum;
    logic                    err_q, inflight, wp, rp;
    logic [1:0]              cnt;
    logic [DataWidth-1:0]    fifo_mem [2];
    logic                    accept, rsv, clr, last, pop, issue, wr_load;

`ifdef MPC_VEC_CLEAR_EN
    localparam state_t op2_state = CLEAR;
    assign rsv = bus.cmd_op == 2'd3;
    assign clr = state == CLEAR;
`else
    localparam state_t op2_state = DONE;
    assign rsv = bus.cmd_op[1];
    assign clr = 1'b0;
`endif

    assign accept   = bus.cmd_valid && state == IDLE;
    assign avail    = ({1'b0, bus.cmd_base} >= range_w) ? '0 : range_w - {1'b0, bus.cmd_base};
    assign eff      = (bus.cmd_len < avail) ? bus.cmd_len : avail;
    assign last     = idx + one_w == len;
    assign wr_load  = state == LOAD && bus.in_valid;
    assign pop      = state == DUMP && cnt != 2'd0 && bus.out_ready;
    // a same-cycle pop frees a slot, which is what keeps the read stream at one word per cycle
    assign issue    = state == DUMP && idx < len && ((cnt + {1'b0, inflight}) < 2'd2 || pop);
    assign addr_sum = {1'b0, base} + idx;

    assign bus.cmd_ready    = state == IDLE;
    assign bus.busy         = state != IDLE;
    assign bus.done         = state == DONE;
    assign bus.err          = err_q;
    assign bus.in_ready     = state == LOAD;
    assign bus.out_valid    = cnt != 2'd0;
    assign bus.out_data     = fifo_mem[rp];
    assign bus.ram_ce0      = wr_load || issue || clr;
    assign bus.ram_we0      = wr_load || clr;
    assign bus.ram_d0       = state == LOAD ? bus.in_data : '0;
    assign bus.ram_address0 = bus.ram_ce0 ? addr_sum[AddressWidth-1:0] : '0;

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (bus.cmd_valid) nstate = (rsv || eff == '0) ? DONE :
                                              bus.cmd_op == 2'd0 ? LOAD :
                                              bus.cmd_op == 2'd1 ? DUMP : op2_state;
            LOAD: if (bus.in_valid && last) nstate = DONE;
            DUMP: if (pop && cnt == 2'd1 && !inflight && idx == len) nstate = DONE;
            DONE: nstate = IDLE;
            default: nstate = clr ? (last ? DONE : state) : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            idx         <= '0;
            err_q       <= 1'b0;
            inflight    <= 1'b0;
            wp          <= 1'b0;
            rp          <= 1'b0;
            cnt         <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                base  <= bus.cmd_base;
                len   <= eff;
                idx   <= '0;
                err_q <= rsv || eff < bus.cmd_len;
            end else if (wr_load || issue || clr) begin
                idx <= idx + one_w;
            end
            inflight <= issue;
            if (inflight) begin
                fifo_mem[wp] <= bus.ram_q0;
                wp           <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_mpc_qp_admm_vec_port_ctrl.sv
// tb_mpc_qp_admm_vec_port_ctrl: directed bench for the vector port controller with a 24x32 read-first RAM.
module tb_mpc_qp_admm_vec_port_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mpc_qp_admm_vec_port_ctrl_if bus ();
    mpc_qp_admm_vec_port_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] mem [24];
    logic [31:0] got [8];
    int checks = 0, errors = 0;
    int done_cnt = 0, ce_cnt = 0, addr_bad = 0;
    int d0, c0, n;

    always @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.ram_ce0) begin
            ce_cnt <= ce_cnt + 1;
            if (bus.ram_address0 >= 5'd24) addr_bad <= addr_bad + 1;
            else begin
                if (bus.ram_we0) mem[bus.ram_address0] <= bus.ram_d0;
                bus.ram_q0 <= mem[bus.ram_address0];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [4:0] base, input logic [5:0] len);
        bus.cmd_op = op;
        bus.cmd_base = base;
        bus.cmd_len = len;
        bus.cmd_valid = 1'b1;
        #1;
        check("cmd_ready", 32'(bus.cmd_ready), 1);
        cyc();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_base = 0; bus.cmd_len = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
        cyc(); cyc();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_ce0", 32'(bus.ram_ce0), 0);
        check("rst_addr", 32'(bus.ram_address0), 0);
        check("rst_out_data", bus.out_data, 0);
        reset = 0;
        bus.in_valid = 1; bus.in_data = 32'hdead;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 0);
        check("idle_ce0", 32'(bus.ram_ce0), 0);

        // 1: full-range LOAD
        d0 = done_cnt;
        cmd(2'd0, 5'd0, 6'd24);
        for (int i = 0; i < 24; i++) begin
            bus.in_data = 32'h100 + i;
            #1;
            check("ld_we", {30'd0, bus.ram_ce0, bus.ram_we0}, 3);
            check("ld_addr", 32'(bus.ram_address0), i);
            cyc();
        end
        bus.in_valid = 0;
        check("ld_done", 32'(bus.done), 1);
        check("ld_err", 32'(bus.err), 0);
        cyc();
        check("ld_idle", 32'(bus.cmd_ready), 1);
        check("ld_done_cnt", done_cnt - d0, 1);
        for (int i = 0; i < 24; i++) check("ld_mem", mem[i], 32'h100 + i);

        // 2: DUMP back-to-back
        bus.out_ready = 1;
        d0 = done_cnt;
        cmd(2'd1, 5'd4, 6'd8);
        check("dp_lat0", 32'(bus.out_valid), 0);
        cyc();
        check("dp_lat1", 32'(bus.out_valid), 0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            check("dp_valid", 32'(bus.out_valid), 1);
            check("dp_data", bus.out_data, 32'h104 + k);
            cyc();
        end
        check("dp_done", 32'(bus.done), 1);
        check("dp_empty", 32'(bus.out_valid), 0);
        cyc();
        check("dp_done_cnt", done_cnt - d0, 1);

        // 3: DUMP with toggling ready and a stall
        n = 0;
        cmd(2'd1, 5'd0, 6'd6);
        for (int t = 0; t < 60 && !bus.done; t++) begin
            bus.out_ready = (t >= 4 && t < 7) ? 1'b0 : 1'(t % 2);
            #1;
            if (bus.out_valid && bus.out_ready && n < 8) begin
                got[n] = bus.out_data;
                n++;
            end
            cyc();
        end
        check("bp_done", 32'(bus.done), 1);
        check("bp_count", n, 6);
        for (int k = 0; k < 6; k++) check("bp_data", got[k], 32'h100 + k);
        bus.out_ready = 0;
        cyc();

        // 4: truncated LOAD and out-of-range DUMP
        bus.in_valid = 1;
        cmd(2'd0, 5'd20, 6'd10);
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 32'h200 + i;
            #1;
            check("tr_addr", 32'(bus.ram_address0), 20 + i);
            cyc();
        end
        bus.in_valid = 0;
        check("tr_done", 32'(bus.done), 1);
        check("tr_err", 32'(bus.err), 1);
        cyc();
        check("tr_err_hold", 32'(bus.err), 1);
        for (int i = 0; i < 4; i++) check("tr_mem", mem[20 + i], 32'h200 + i);
        c0 = ce_cnt;
        cmd(2'd1, 5'd30, 6'd1);
        check("oor_done", 32'(bus.done), 1);
        check("oor_err", 32'(bus.err), 1);
        cyc();
        check("oor_no_ce", ce_cnt - c0, 0);
        cmd(2'd3, 5'd0, 6'd4);
        check("rsv_done", 32'(bus.done), 1);
        check("rsv_err", 32'(bus.err), 1);
        cyc();
        cmd(2'd0, 5'd3, 6'd0);
        check("zlen_done", 32'(bus.done), 1);
        check("zlen_err", 32'(bus.err), 0);
        cyc();
        check("zlen_no_ce", ce_cnt - c0, 0);

        // 5: reset in the middle of a DUMP
        bus.out_ready = 1;
        cmd(2'd1, 5'd0, 6'd8);
        cyc(); cyc();
        for (int k = 0; k < 3; k++) begin
            check("ab_data", bus.out_data, 32'h100 + k);
            cyc();
        end
        reset = 1;
        cyc();
        check("ab_out_valid", 32'(bus.out_valid), 0);
        check("ab_ce0", 32'(bus.ram_ce0), 0);
        check("ab_cmd_ready", 32'(bus.cmd_ready), 1);
        c0 = ce_cnt;
        cyc();
        check("ab_no_ce", ce_cnt - c0, 0);
        reset = 0;
        cmd(2'd1, 5'd10, 6'd2);
        check("ab2_err", 32'(bus.err), 0);
        cyc(); cyc();
        check("ab2_d0", bus.out_data, 32'h10A);
        cyc();
        check("ab2_d1", bus.out_data, 32'h10B);
        cyc();
        check("ab2_done", 32'(bus.done), 1);
        cyc();

        // 6: CLEAR (or reserved without the feature)
        c0 = ce_cnt;
        cmd(2'd2, 5'd2, 6'd3);
`ifdef MPC_VEC_CLEAR_EN
        for (int i = 0; i < 3; i++) begin
            check("cl_we", {30'd0, bus.ram_ce0, bus.ram_we0}, 3);
            check("cl_addr", 32'(bus.ram_address0), 2 + i);
            cyc();
        end
        check("cl_done", 32'(bus.done), 1);
        check("cl_err", 32'(bus.err), 0);
        cyc();
        for (int i = 2; i < 5; i++) check("cl_mem", mem[i], 0);
`else
        check("cl_done", 32'(bus.done), 1);
        check("cl_err", 32'(bus.err), 1);
        cyc();
        check("cl_no_ce", ce_cnt - c0, 0);
        for (int i = 2; i < 5; i++) check("cl_mem", mem[i], 32'h100 + i);
`endif
        check("cl_mem1", mem[1], 32'h101);
        check("cl_mem5", mem[5], 32'h105);
        check("addr_range", addr_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
